seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Sequential restoring divider, the inverse of the team's shift-add multiplier.
//   It divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor.
//   Each step shifts the partial remainder left, trial-subtracts the divisor, and restores on borrow.
//   Quotient and remainder are ready WIDTH cycles after start.
//   Sits beside the multiplier in the arithmetic unit and is driven by a simple start/done handshake.
// PARAMETERS
//   WIDTH   4   operand width in bits; quotient and remainder are each WIDTH bits
// PORTS
//   clk           in   1      single clock; all state changes on the rising edge
//   rst           in   1      synchronous, active-high reset
//   start         in   1      request; accepted only on an edge where busy=0
//   dividend      in   WIDTH  sampled on the accept edge only
//   divisor       in   WIDTH  sampled on the accept edge only
//   busy          out  1      high while an operation is in progress (RUN)
//   done          out  1      one-cycle pulse; results valid in that cycle
//   quotient      out  WIDTH  registered; held until the next accepted start
//   remainder     out  WIDTH  registered; held until the next accepted start
//   div_by_zero   out  1      registered; qualifies the result; held with it
// BEHAVIOUR
//   Clock and reset:
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - rst overrides everything, including an operation in progress.
//   - Reset values: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder, count = 0.
//   States: IDLE, RUN, DONE.
//   IDLE:
//   - start=1 on edge E0: load M=divisor, Q=dividend, A=0 (WIDTH+1 bits), count=WIDTH.
//   - Then go to RUN. busy reads 1 from the cycle after E0.
//   - If divisor==0 at E0: skip RUN and go directly to DONE.
//     quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
//   RUN, one iteration per edge (E1..E_WIDTH):
//   - {A,Q} = {A,Q} << 1.
//   - T = A - {1'b0,M}, computed at WIDTH+1 bits.
//   - If T[WIDTH]==0: A=T and Q[0]=1. Otherwise A is kept (restore) and Q[0]=0.
//   - count decrements each iteration.
//   - The edge where count reaches 0 (E_WIDTH) enters DONE.
//     It also writes quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=0.
//   DONE:
//   - done=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
//   - start is ignored while in DONE.
//   Latency:
//   - Normal case: done is high in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after the accept edge.
//   - Divide by zero: done is high in the cycle after E0.
//   Boundary conditions:
//   - start while busy=1 or done=1 is ignored. No queueing, no effect on the operation in flight.
//   - Operand changes after E0 have no effect.
//   - start held continuously: a new accept occurs on the first edge in IDLE after the DONE cycle.
//     Back-to-back throughput is one result per WIDTH+2 cycles.
//   - dividend < divisor: quotient=0, remainder=dividend.
//   - dividend==0, divisor!=0: quotient=0, remainder=0.
//   - rst during RUN aborts the operation. There is no done pulse, and outputs take their reset values.
//   Invariants:
//   - The A register is WIDTH+1 bits, so the trial-subtract borrow is never lost.
//   - When div_by_zero=0, quotient*divisor + remainder == dividend and remainder < divisor.
// STRUCTURE
//   Shared package div_pkg:
//   - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//   - DIV_WIDTH_DEFAULT=4.
//   Sub-module div_step (combinational):
//   - inputs {A,Q}, M; outputs next {A,Q}.
//   - Performs one shift, trial-subtract and restore; instantiated once.
//   Top level: FSM, count register, operand/result registers, handshake.
// TESTING
//   1. 13/4, WIDTH=4 -> done exactly 5 cycles after the accept edge; quotient=3, remainder=1, dbz=0.
//   2. 15/1 and 0/7 -> (15,0) and (0,0); busy high for exactly 4 cycles each.
//   3. 3/9 -> quotient=0, remainder=3; 9/0 -> done 1 cycle after accept, quotient=4'hF, remainder=9, dbz=1.
//   4. start pulsed again 2 cycles into 12/5 with operands 1/1 -> ignored; result 2 r 2, single done pulse.
//   5. rst asserted on the 2nd RUN cycle of 14/3 -> next cycle: state IDLE, all outputs 0, no done.
//      A following 14/3 then yields 4 r 2.
//   6. Exhaustive sweep of all 256 operand pairs, start held high -> results match / and %,
//      divide by zero checked, one done per WIDTH+2 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state type for the sequential divider
// Purpose: state encoding and default operand width used by seq_divider and its bench.
// Contents: DIV_WIDTH_DEFAULT, S_IDLE/S_RUN/S_DONE encodings, state_t enum.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration (shift, trial subtract, restore)
// Purpose: combinational single step of the restoring divider.
// Ports:
//   a      in  WIDTH+1  partial remainder
//   q      in  WIDTH    dividend bits being shifted out / quotient bits shifted in
//   m      in  WIDTH    divisor
//   a_next out WIDTH+1  partial remainder after this step
//   q_next out WIDTH    quotient/dividend register after this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {a, q} << 1;
        a_sh    = shifted[2*WIDTH:WIDTH];
        q_sh    = shifted[WIDTH-1:0];
        // A is WIDTH+1 bits so the borrow lands in trial[WIDTH] instead of being lost.
        trial   = a_sh - {1'b0, m};
        a_next  = a_sh;
        q_next  = q_sh;
        if (!trial[WIDTH]) begin
            a_next = trial;
            q_next = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider with start/done handshake
// Purpose: unsigned WIDTH-bit divide; result WIDTH+1 cycles after accept (1 cycle on divide by zero).
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   start        in   1      request, accepted only in IDLE
//   dividend     in   WIDTH  sampled on the accept edge
//   divisor      in   WIDTH  sampled on the accept edge
//   busy         out  1      high while iterating
//   done         out  1      one-cycle result pulse
//   quotient     out  WIDTH  registered result
//   remainder    out  WIDTH  registered result
//   div_by_zero  out  1      registered, qualifies the result
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .q      (q),
        .m      (m),
        .a_next (a_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            count       <= '0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= divisor;
                        q     <= dividend;
                        a     <= '0;
                        count <= CW'(WIDTH);
                        if (divisor == '0) begin
                            // No iterations needed: report immediately.
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    a     <= a_next;
                    q     <= q_next;
                    count <= count - CW'(1);
                    // Last iteration: capture the step outputs directly as the result.
                    if (count == CW'(1)) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= a_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
